// File: rtl/hs32_pkg.sv
// Shared definitions for the hs32 device-side bus: arbiter state encodings
// and master count.
package hs32_pkg;

  localparam int N_MASTERS = 2;
  localparam int OWNER_W   = $clog2(N_MASTERS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: the pointer breaks ties when both masters request.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic idx,
  output logic vld
);

  always_comb begin
    vld = req0 | req1;
    idx = (req0 && req1) ? ptr : req1;
  end

endmodule

// File: rtl/dev_arbiter.sv
// Two-master arbiter onto the shared device bus, with round-robin fairness,
// a per-transaction ack timeout and abort on stb withdrawal.
module dev_arbiter
  import hs32_pkg::*;
#(
  parameter int unsigned TO_CYCLES = 255,
  parameter int unsigned PRIO_M0   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_stb,
  input  logic        m1_stb,
  output logic        m0_ack,
  output logic        m1_ack,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_dtw,
  input  logic [31:0] m1_dtw,
  input  logic        m0_rw,
  input  logic        m1_rw,
  input  logic        m0_user,
  input  logic        m1_user,
  output logic [31:0] m0_dtr,
  output logic [31:0] m1_dtr,
  output logic        s_stb,
  input  logic        s_ack,
  output logic [31:0] s_addr,
  output logic [31:0] s_dtw,
  output logic        s_rw,
  output logic        s_user,
  input  logic [31:0] s_dtr,
  output logic        o_timeout,
  output logic [1:0]  o_owner
);

  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);
  localparam logic       RR_INIT = (PRIO_M0 != 0);

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic [OWNER_W-1:0] owner;
  logic               rr_ptr;
  logic [7:0]         to_cnt;
  logic               pick_idx;
  logic               pick_vld;
  logic               busy;
  logic               owner_stb;
  logic               hit_ack;
  logic               hit_to;
  logic               ack_any;

  rr_pick2 u_pick (
    .req0 (m0_stb),
    .req1 (m1_stb),
    .ptr  (rr_ptr),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  // An owner that withdraws stb suppresses both ack sources (abort).
  always_comb begin
    busy      = (state == ST_BUSY);
    owner_stb = owner[0] ? m1_stb : m0_stb;
    hit_ack   = busy && owner_stb && s_ack;
    hit_to    = busy && owner_stb && !s_ack && (to_cnt == TO_LAST);
    ack_any   = hit_ack || hit_to;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pick_vld) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (!owner_stb)   state_nxt = ST_IDLE;
        else if (ack_any) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner  <= '0;
      rr_ptr <= RR_INIT;
      to_cnt <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            owner  <= pick_idx;
            to_cnt <= 8'd0;
          end
        end
        ST_BUSY: begin
          if (owner_stb) begin
            if (ack_any) rr_ptr <= ~owner[0];
            else         to_cnt <= to_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_stb     = 1'b0;
    s_addr    = 32'h0;
    s_dtw     = 32'h0;
    s_rw      = 1'b0;
    s_user    = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_dtr    = 32'h0;
    m1_dtr    = 32'h0;
    o_timeout = 1'b0;
    o_owner   = 2'b00;
    if (busy) begin
      s_stb     = owner_stb;
      s_addr    = owner[0] ? m1_addr : m0_addr;
      s_dtw     = owner[0] ? m1_dtw  : m0_dtw;
      s_rw      = owner[0] ? m1_rw   : m0_rw;
      s_user    = owner[0] ? m1_user : m0_user;
      o_owner   = {1'b1, owner};
      o_timeout = hit_to;
      m0_ack    = ack_any && !owner[0];
      m1_ack    = ack_any &&  owner[0];
      // Timeout terminations return zero data; only a real ack forwards s_dtr.
      if (hit_ack && !owner[0]) m0_dtr = s_dtr;
      if (hit_ack &&  owner[0]) m1_dtr = s_dtr;
    end
  end

endmodule

// File: tb/tb_dev_arbiter.sv
// Directed, table-driven bench for dev_arbiter with a short ack timeout.
module tb_dev_arbiter;

  localparam logic [31:0] A0 = 32'h0000_FF00;
  localparam logic [31:0] A1 = 32'h1234_5678;
  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] D1 = 32'hB1B1_1111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_stb, m1_stb, m0_ack, m1_ack;
  logic [31:0] m0_addr, m1_addr, m0_dtw, m1_dtw, m0_dtr, m1_dtr;
  logic        m0_rw, m1_rw, m0_user, m1_user;
  logic        s_stb, s_ack, s_rw, s_user, o_timeout;
  logic [31:0] s_addr, s_dtw, s_dtr;
  logic [1:0]  o_owner;

  typedef struct {
    logic        m0s;
    logic        m1s;
    logic        sack;
    logic [31:0] sdtr;
    logic        m0a;
    logic        m1a;
    logic [31:0] m0d;
    logic [31:0] m1d;
    logic        sstb;
    logic [1:0]  own;
    logic        tmo;
  } vec_t;

  vec_t tv[$];
  int   applied = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dev_arbiter #(.TO_CYCLES(4), .PRIO_M0(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_stb(m0_stb), .m1_stb(m1_stb), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dtw(m0_dtw), .m1_dtw(m1_dtw),
    .m0_rw(m0_rw), .m1_rw(m1_rw), .m0_user(m0_user), .m1_user(m1_user),
    .m0_dtr(m0_dtr), .m1_dtr(m1_dtr),
    .s_stb(s_stb), .s_ack(s_ack), .s_addr(s_addr), .s_dtw(s_dtw),
    .s_rw(s_rw), .s_user(s_user), .s_dtr(s_dtr),
    .o_timeout(o_timeout), .o_owner(o_owner)
  );

  task automatic add(input logic m0s, input logic m1s, input logic sack,
                     input logic [31:0] sdtr, input logic m0a, input logic m1a,
                     input logic [31:0] m0d, input logic [31:0] m1d,
                     input logic sstb, input logic [1:0] own, input logic tmo);
    vec_t v;
    v.m0s = m0s; v.m1s = m1s; v.sack = sack; v.sdtr = sdtr;
    v.m0a = m0a; v.m1a = m1a; v.m0d = m0d; v.m1d = m1d;
    v.sstb = sstb; v.own = own; v.tmo = tmo;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    m0_stb = v.m0s;
    m1_stb = v.m1s;
    s_ack  = v.sack;
    s_dtr  = v.sdtr;
  endtask

  // Bus-side fields follow from the expected owner: the granted master's
  // fixed address/data/rw/user while valid, zero otherwise.
  task automatic chk_vec(input vec_t v, input int idx);
    logic [31:0] ea, ed;
    logic        er, eu;
    ea = 32'h0; ed = 32'h0; er = 1'b0; eu = 1'b0;
    if (v.own[1]) begin
      ea = v.own[0] ? A1 : A0;
      ed = v.own[0] ? D1 : D0;
      er = v.own[0];
      eu = v.own[0];
    end
    applied++;
    chk("m0_ack",    idx, {31'h0, m0_ack},    {31'h0, v.m0a});
    chk("m1_ack",    idx, {31'h0, m1_ack},    {31'h0, v.m1a});
    chk("m0_dtr",    idx, m0_dtr,             v.m0d);
    chk("m1_dtr",    idx, m1_dtr,             v.m1d);
    chk("s_stb",     idx, {31'h0, s_stb},     {31'h0, v.sstb});
    chk("o_owner",   idx, {30'h0, o_owner},   {30'h0, v.own});
    chk("o_timeout", idx, {31'h0, o_timeout}, {31'h0, v.tmo});
    chk("s_addr",    idx, s_addr,             ea);
    chk("s_dtw",     idx, s_dtw,              ed);
    chk("s_rw",      idx, {31'h0, s_rw},      {31'h0, er});
    chk("s_user",    idx, {31'h0, s_user},    {31'h0, eu});
  endtask

  initial begin
    vec_t v;
    m0_addr = A0; m1_addr = A1; m0_dtw = D0; m1_dtw = D1;
    m0_rw = 1'b0; m1_rw = 1'b1; m0_user = 1'b0; m1_user = 1'b1;
    s_ack = 1'b1; s_dtr = 32'h1234; m0_stb = 1'b1; m1_stb = 1'b1;
    reset_n = 1'b0;

    //  m0s m1s ack sdtr           m0a m1a m0d            m1d       stb own    tmo
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    // both held: grants alternate m0, m1, m0 from the reset pointer
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,    1, 2'b10, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,    1, 2'b10, 0);
    add(1, 1, 1, 32'h1,          1, 0, 32'h1,          32'h0,    1, 2'b10, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,    1, 2'b11, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,    1, 2'b11, 0);
    add(1, 1, 1, 32'h2,          0, 1, 32'h0,          32'h2,    1, 2'b11, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,    1, 2'b10, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,    1, 2'b10, 0);
    add(1, 1, 1, 32'h3,          1, 0, 32'h3,          32'h0,    1, 2'b10, 0);
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    // single m0 read acked in its first BUSY cycle; s_ack in DONE/IDLE ignored
    add(1, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(1, 0, 1, 32'hDEAD_BEEF,  1, 0, 32'hDEAD_BEEF,  32'h0,    1, 2'b10, 0);
    add(0, 0, 1, 32'h5555,       0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(0, 0, 1, 32'h5555,       0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    // m1 write never acked: timeout in the fourth BUSY cycle with zero data
    add(0, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(0, 1, 0, 32'h77,         0, 0, 32'h0,          32'h0,    1, 2'b11, 0);
    add(0, 1, 0, 32'h77,         0, 0, 32'h0,          32'h0,    1, 2'b11, 0);
    add(0, 1, 0, 32'h77,         0, 0, 32'h0,          32'h0,    1, 2'b11, 0);
    add(0, 1, 0, 32'h77,         0, 1, 32'h0,          32'h0,    1, 2'b11, 1);
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    // s_ack lands on the timeout cycle: real ack wins
    add(1, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(1, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    1, 2'b10, 0);
    add(1, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    1, 2'b10, 0);
    add(1, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    1, 2'b10, 0);
    add(1, 0, 1, 32'hCAFE_F00D,  1, 0, 32'hCAFE_F00D,  32'h0,    1, 2'b10, 0);
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    // m1 transaction returns the pointer to m0, then m0 aborts
    add(0, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(0, 1, 1, 32'h9,          0, 1, 32'h0,          32'h9,    1, 2'b11, 0);
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(1, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(1, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    1, 2'b10, 0);
    add(0, 0, 1, 32'hBAD,        0, 0, 32'h0,          32'h0,    0, 2'b10, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(1, 1, 1, 32'hA,          1, 0, 32'hA,          32'h0,    1, 2'b10, 0);
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,    0, 2'b00, 0);

    // outputs held at zero under reset even with requests and s_ack active
    #2;
    v = '{1, 1, 1, 32'h1234, 0, 0, 32'h0, 32'h0, 0, 2'b00, 0};
    chk_vec(v, -1);
    @(negedge clk);
    reset_n = 1'b1;
    m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b0; s_dtr = 32'h0;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      #2;
      chk_vec(tv[i], i);
    end

    // reset pulse between edges while m1 owns the bus (pointer currently m1)
    @(negedge clk);
    v = '{0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b00, 0};
    drive(v);
    #2;
    chk_vec(v, 100);
    @(negedge clk);
    v = '{0, 1, 1, 32'h42, 0, 1, 32'h0, 32'h42, 1, 2'b11, 0};
    drive(v);
    #1;
    chk_vec(v, 101);
    reset_n = 1'b0;
    #1;
    v = '{0, 1, 1, 32'h42, 0, 0, 32'h0, 32'h0, 0, 2'b00, 0};
    chk_vec(v, 102);
    #1;
    reset_n = 1'b1;
    v = '{1, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b00, 0};
    drive(v);
    @(negedge clk);
    #2;
    v = '{1, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 2'b10, 0};
    chk_vec(v, 103);
    @(negedge clk);
    v = '{1, 1, 1, 32'h77, 1, 0, 32'h77, 32'h0, 1, 2'b10, 0};
    drive(v);
    #2;
    chk_vec(v, 104);
    @(negedge clk);
    m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/dev_arbiter.md
DEV_ARBITER -- requirements
Module: dev_arbiter

Interface
REQ-001 Parameter TO_CYCLES, default 255: maximum cycles a granted transaction may wait for ack before forced termination (range 1..255).
REQ-002 Parameter PRIO_M0, default 0: initial round-robin pointer after reset (0 selects master 0 first).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 m0_stb, m1_stb  in  1 each  master request, held high until that master's ack.
REQ-006 m0_ack, m1_ack  out  1 each  single-cycle completion pulse to the owning master.
REQ-007 m0_addr, m1_addr  in  32 each  transaction address.
REQ-008 m0_dtw, m1_dtw  in  32 each  write data.
REQ-009 m0_rw, m1_rw  in  1 each  1 = write, 0 = read.
REQ-010 m0_user, m1_user  in  1 each  requester usermode bit.
REQ-011 m0_dtr, m1_dtr  out  32 each  read data, valid only in the ack cycle, zero otherwise.
REQ-012 s_stb  out  1; s_ack  in  1; s_addr  out  32; s_dtw  out  32; s_rw  out  1; s_user  out  1; s_dtr  in  32: shared downstream bus to the device interconnect.
REQ-013 o_timeout  out  1  single-cycle pulse when a transaction is force-terminated.
REQ-014 o_owner  out  2  {valid, index} of current grant, for debug.

Function
REQ-015 FSM states: IDLE, BUSY, DONE, with registered state, owner index, RR pointer and 8-bit timeout counter.
REQ-016 IDLE: no request -> stay; one request -> grant that master; both -> grant the master selected by the RR pointer; the grant takes effect at the next edge, in BUSY.
REQ-017 BUSY: s_stb = owner's stb; s_addr/s_dtw/s_rw/s_user = owner's signals, combinational from the registered owner; all s_* outputs are zero outside BUSY.
REQ-018 BUSY with s_ack = 1 (including s_ack in the first BUSY cycle): owner ack = 1 and owner dtr = s_dtr in that same cycle; RR pointer moves to the other master; next state DONE.
REQ-019 DONE lasts one cycle, ignores s_ack and returns to IDLE, so each master's stb has dropped before re-arbitration.
REQ-020 Latency: request seen in IDLE at cycle N -> s_stb at N+1; earliest master ack at N+1; minimum issue-to-issue spacing is 3 cycles.
REQ-021 Timeout counter clears on entry to BUSY and increments each BUSY cycle without s_ack; when the counter reaches TO_CYCLES: owner ack = 1, owner dtr = 32'h0, o_timeout = 1, RR pointer advances, next state DONE.
REQ-022 s_ack and timeout in the same cycle: s_ack wins; dtr = s_dtr and o_timeout = 0.
REQ-023 Owner drops stb in BUSY before ack: abort; s_stb = 0 that cycle, no ack, RR pointer unchanged, next state IDLE.
REQ-024 s_ack outside BUSY is ignored; never produces a master ack.
REQ-025 At most one of m0_ack or m1_ack is high in any cycle; the non-owner's ack and dtr are always 0.
REQ-026 o_owner = {1, owner} in BUSY, 2'b00 otherwise.

Reset
REQ-027 reset_n low: state IDLE, owner 0, RR pointer PRIO_M0, counter 0, all outputs 0, asynchronously.
REQ-028 Reset asserted mid-transaction drops s_stb immediately with no ack to either master; reset release is synchronised by the integrating top, not by this block.

Structure
REQ-029 FSM state encodings and the master-count constant (2) belong in the shared hs32 package.
REQ-030 Single sub-module rr_pick2 (two requests plus pointer -> grant index and valid), purely combinational; everything else is flat.

Verification
REQ-031 Only m0_stb with m0_addr 32'h0000_FF00 read, s_ack at the first BUSY cycle with s_dtr 32'hDEAD_BEEF -> m0_ack at N+1, m0_dtr 32'hDEAD_BEEF, m1_ack stays 0.
REQ-032 Both stb held continuously, s_ack 2 cycles after each s_stb -> grants alternate m0, m1, m0, m1 starting from PRIO_M0, with no overlapping s_stb.
REQ-033 m1 write, s_ack never asserted, TO_CYCLES = 4 -> m1_ack plus o_timeout after 4 BUSY cycles, m1_dtr 0, DONE then IDLE.
REQ-034 s_ack and timeout coincide -> ack with s_dtr, o_timeout = 0.
REQ-035 m0 drops stb in the second BUSY cycle -> s_stb falls that cycle, no ack, next grant still follows the unchanged pointer.
REQ-036 reset_n pulsed low in BUSY between clock edges -> s_stb and o_owner go to 0 before the next edge, and the first grant after release follows PRIO_M0.
